fifo_sync: RTL and testbench
============================

# fifo_sync

Single-clock, synchronous FIFO buffer: the device-under-test stage between the file-driven write-side stimulus (source of `wr_en`/`wr_data`) and the file-capturing read-side stimulus (sink draining `rd_en`/`rd_data`). Stores BYTE_WIDTH-byte words in order and applies backpressure to the source through `wr_full`. Exposes the empty flag so the sink can throttle its reads. Word format and flag behaviour are byte-exact with the stimulus blocks, so a bench run reproduces the input file at the output.

## Interface
- BYTE_WIDTH, 14, word width in bytes; data buses are BYTE_WIDTH*8 bits.
- FIFO_DEPTH, 256, number of words stored; power of two, minimum 4.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `wr_en`  in  1  write request.
- `wr_data`  in  BYTE_WIDTH*8  write word.
- `wr_ack`  out  1  one-cycle pulse confirming a write was accepted.
- `wr_full`  out  1  FIFO holds FIFO_DEPTH words; writes are rejected.
- `rd_en`  in  1  read request.
- `rd_data`  out  BYTE_WIDTH*8  read word, registered.
- `rd_valid`  out  1  `rd_data` carries a newly read word this cycle.
- `rd_empty`  out  1  FIFO holds zero words; reads are rejected.
- `data_count`  out  clog2(FIFO_DEPTH)+1  occupancy in words (see Configuration).

## Operation
- Storage:
  - FIFO_DEPTH × BYTE_WIDTH*8 memory.
  - Write and read pointers are clog2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - The low bits address the memory.
  - Equal pointers mean empty.
  - Pointers that differ only in the MSB mean full.
- Write accept: `wr_en` && !`wr_full` at the clock edge.
  - The word is stored at the write pointer and the pointer increments.
  - A write request while full is dropped: no store, no pointer change, no `wr_ack`.
- Read accept: `rd_en` && !`rd_empty` at the clock edge.
  - The memory word at the read pointer is registered into `rd_data` and the pointer increments.
  - A read request while empty is ignored.
- Acceptance uses the flag values present before the edge (registered flags).
- Simultaneous requests:
  - When empty: only the write is accepted.
  - When full: only the read is accepted.
  - Otherwise both are accepted and occupancy is unchanged.
- Occupancy after an edge is old + write accepted − read accepted.
  - `wr_full` and `rd_empty` are recomputed from the post-edge pointers.
- `rd_data` holds its last value when no read is accepted.
- No state machine beyond the pointer pair and the flag registers. No overflow or underflow state is reachable.

## Timing
- Reset values (asynchronous, immediate on `rst`=1): `wr_full`=0, `rd_empty`=1, `wr_ack`=0, `rd_valid`=0, `rd_data`=0, `data_count`=0, both pointers=0.
- While `rst`=1, all requests are ignored.
- Reset during traffic discards all stored words. The first write accepted after release is also the first word read.
- Write latency:
  - `wr_ack` goes high in the cycle after the accepting edge, for exactly one cycle per accepted write.
  - Back-to-back accepted writes hold `wr_ack` high continuously.
- Read latency:
  - `rd_data`/`rd_valid` are valid in the cycle after the accepting edge.
  - `rd_valid` is high for one cycle per accepted read.
- Flag latency:
  - `rd_empty` deasserts the cycle after the first write into an empty FIFO.
  - A word written at edge N can be read at edge N+1, with data out after edge N+1.
  - `wr_full` asserts in the cycle after the write that brings occupancy to FIFO_DEPTH.
  - `wr_full` deasserts in the cycle after the first read from full.
- Wrap-around: pointers roll past FIFO_DEPTH−1 with no bubble and no loss of ordering.

## Configuration
- Macro `FIFO_DATA_COUNT_EN`:
  - Defined: `data_count` is a registered occupancy counter, updated on the same edge as the flags. Range 0..FIFO_DEPTH.
  - Undefined: the counter logic is omitted and `data_count` is tied to 0. Flags and data behaviour are identical.

## Test plan
- Fill: reset, then hold `wr_en`=1 with `rd_en`=0 and incrementing data 0,1,2,….
  - 256 `wr_ack` pulses, then `wr_full`=1 and `wr_ack`=0 from the 257th request on.
  - `data_count`=256.
- Drain: continue from full with `rd_en`=1 held.
  - `rd_valid` high for 256 cycles carrying words 0..255 in order.
  - `rd_empty`=1 the cycle after the last read; no further `rd_valid`.
- Streaming with wrap: write and read simultaneously for 1000 words at depth 256.
  - Output sequence equals input sequence.
  - Occupancy holds constant at its pre-stream value.
- Boundary simultaneity:
  - At empty with both requests asserted: only the write is accepted and `rd_valid`=0.
  - At full with both requests asserted: only the read is accepted, `wr_ack`=0 and `data_count` decrements to 255.
- Mid-operation reset: write 10 words, read 3, assert `rst` asynchronously between edges.
  - All outputs immediately take their reset values.
  - After release, write 0xAA…: the first read returns 0xAA….
- File loopback: source and sink stimulus blocks connected as in the bench, with `rd_en` = ~downstream full and the sink randomly full.
  - The output file is byte-identical to the input file.
  - `wr_full` throttles the source without loss.

Source files
------------

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with registered flags, one-cycle write ack and registered read data.
//   Parameters: BYTE_WIDTH (word width in bytes), FIFO_DEPTH (words, power of two >= 4)
//   Ports: clk, rst (async active-high), wr_en/wr_data -> wr_ack/wr_full,
//          rd_en -> rd_data/rd_valid/rd_empty, data_count (occupancy)
//   Macro FIFO_DATA_COUNT_EN: when defined data_count is a registered occupancy counter,
//   otherwise data_count is tied to 0.
module fifo_sync #(
  parameter int BYTE_WIDTH = 14,
  parameter int FIFO_DEPTH = 256,
  localparam int DW = BYTE_WIDTH * 8,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_empty,
  output logic [AW:0]   data_count
);
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full_q, full_d, empty_q, empty_d, wr_ack_q, rd_valid_q;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          wr_acc, rd_acc;

  // Acceptance looks only at the registered flags, so a simultaneous read
  // never makes room for a write in the same cycle (and vice versa).
  always_comb begin
    wr_acc    = wr_en && !full_q;
    rd_acc    = rd_en && !empty_q;
    wr_ptr_d  = wr_ptr_q + (AW+1)'(wr_acc);
    rd_ptr_d  = rd_ptr_q + (AW+1)'(rd_acc);
    empty_d   = wr_ptr_d == rd_ptr_d;
    full_d    = (wr_ptr_d ^ rd_ptr_d) == {1'b1, {AW{1'b0}}};
    rd_data_d = rd_acc ? mem[rd_ptr_q[AW-1:0]] : rd_data_q;
  end

  always_ff @(posedge clk)
    if (wr_acc && !rst) mem[wr_ptr_q[AW-1:0]] <= wr_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      wr_ack_q   <= wr_acc;
      rd_valid_q <= rd_acc;
      rd_data_q  <= rd_data_d;
    end

`ifdef FIFO_DATA_COUNT_EN
  logic [AW:0] count_q, count_d;
  always_comb count_d = count_q + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign data_count = count_q;
`else
  assign data_count = '0;
`endif

  assign wr_ack   = wr_ack_q;
  assign wr_full  = full_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_empty = empty_q;
endmodule

// File: tb/tb_fifo_sync.sv
// tb_fifo_sync: randomized self-checking bench for fifo_sync against a queue-based model.
module tb_fifo_sync;
  localparam int BW = 14;
  localparam int DEPTH = 256;
  localparam int DW = BW * 8;
  localparam int AW = $clog2(DEPTH);

  logic clk, rst, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic wr_ack, wr_full, rd_valid, rd_empty;
  logic [DW-1:0] rd_data;
  logic [AW:0] data_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_data;
  logic exp_ack, exp_valid;

  fifo_sync #(.BYTE_WIDTH(BW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_full(wr_full), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_empty(rd_empty), .data_count(data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  function automatic int exp_cnt();
`ifdef FIFO_DATA_COUNT_EN
    return q.size();
`else
    return 0;
`endif
  endfunction

  // Drive one cycle of requests and advance the model by the FIFO's rules.
  task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re);
    bit aw, ar;
    wr_en = we; wr_data = wd; rd_en = re;
    @(posedge clk);
    aw = we && (q.size() < DEPTH);
    ar = re && (q.size() > 0);
    if (ar) exp_data = q.pop_front();
    if (aw) q.push_back(wd);
    exp_ack = aw; exp_valid = ar;
    #1;
  endtask

  task automatic model_reset();
    q.delete(); exp_data = '0; exp_ack = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0b want 0", wr_full); end
    n_cmp++; if (rd_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %0b want 1", rd_empty); end
    n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %0b want 0", wr_ack); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_data: got %0h want 0", rd_data); end
    n_cmp++; if (data_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", data_count); end
    #3 rst = 1'b0;
  endtask

  task automatic test_fill();
    int acks = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      cyc(1'b1, DW'(i), 1'b0);
      if (wr_ack === 1'b1) acks++;
      n_cmp++; if (wr_ack !== (i < DEPTH)) begin n_err++; $display("FAIL fill_ack[%0d]: got %0b want %0b", i, wr_ack, i < DEPTH); end
      n_cmp++; if (wr_full !== (i >= DEPTH - 1)) begin n_err++; $display("FAIL fill_full[%0d]: got %0b want %0b", i, wr_full, i >= DEPTH - 1); end
      n_cmp++; if (rd_empty !== 1'b0) begin n_err++; $display("FAIL fill_empty[%0d]: got %0b want 0", i, rd_empty); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL fill_valid[%0d]: got %0b want 0", i, rd_valid); end
    end
    n_cmp++; if (acks != DEPTH) begin n_err++; $display("FAIL fill_ack_total: got %0d want %0d", acks, DEPTH); end
    n_cmp++; if (int'(data_count) != exp_cnt()) begin n_err++; $display("FAIL fill_count: got %0d want %0d", data_count, exp_cnt()); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH + 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_cmp++; if (rd_valid !== (i < DEPTH)) begin n_err++; $display("FAIL drain_valid[%0d]: got %0b want %0b", i, rd_valid, i < DEPTH); end
      if (i < DEPTH) begin
        n_cmp++; if (rd_data !== DW'(i)) begin n_err++; $display("FAIL drain_data[%0d]: got %0h want %0h", i, rd_data, i); end
      end
      n_cmp++; if (rd_empty !== (i >= DEPTH - 1)) begin n_err++; $display("FAIL drain_empty[%0d]: got %0b want %0b", i, rd_empty, i >= DEPTH - 1); end
      n_cmp++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL drain_full[%0d]: got %0b want 0", i, wr_full); end
      n_cmp++; if (int'(data_count) != exp_cnt()) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, data_count, exp_cnt()); end
    end
  endtask

  task automatic test_boundary();
    logic [DW-1:0] w;
    w = rnd();
    cyc(1'b1, w, 1'b1);
    n_cmp++; if (wr_ack !== 1'b1) begin n_err++; $display("FAIL empty_both_ack: got %0b want 1", wr_ack); end
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL empty_both_valid: got %0b want 0", rd_valid); end
    n_cmp++; if (rd_empty !== 1'b0) begin n_err++; $display("FAIL empty_both_empty: got %0b want 0", rd_empty); end
    while (q.size() < DEPTH) cyc(1'b1, rnd(), 1'b0);
    n_cmp++; if (wr_full !== 1'b1) begin n_err++; $display("FAIL boundary_full: got %0b want 1", wr_full); end
    cyc(1'b1, rnd(), 1'b1);
    n_cmp++; if (wr_ack !== 1'b0) begin n_err++; $display("FAIL full_both_ack: got %0b want 0", wr_ack); end
    n_cmp++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL full_both_valid: got %0b want 1", rd_valid); end
    n_cmp++; if (rd_data !== w) begin n_err++; $display("FAIL full_both_data: got %0h want %0h", rd_data, w); end
    n_cmp++; if (wr_full !== 1'b0) begin n_err++; $display("FAIL full_both_full: got %0b want 0", wr_full); end
`ifdef FIFO_DATA_COUNT_EN
    n_cmp++; if (data_count !== (AW+1)'(DEPTH - 1)) begin n_err++; $display("FAIL full_both_count: got %0d want %0d", data_count, DEPTH - 1); end
`else
    n_cmp++; if (data_count !== '0) begin n_err++; $display("FAIL full_both_count: got %0d want 0", data_count); end
`endif
    while (q.size() > 5) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic test_stream();
    int occ;
    occ = q.size();
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b1, rnd(), 1'b1);
      n_cmp++; if (wr_ack !== 1'b1 || rd_valid !== 1'b1) begin n_err++; $display("FAIL stream_handshake[%0d]: got ack=%0b valid=%0b want 1/1", i, wr_ack, rd_valid); end
      n_cmp++; if (rd_data !== exp_data) begin n_err++; $display("FAIL stream_data[%0d]: got %0h want %0h", i, rd_data, exp_data); end
      n_cmp++; if (int'(data_count) != exp_cnt() || q.size() != occ) begin n_err++; $display("FAIL stream_count[%0d]: got %0d want %0d", i, data_count, exp_cnt()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 55), rnd(), ($urandom_range(0, 99) < 45));
      n_cmp++; if (wr_ack !== exp_ack) begin n_err++; $display("FAIL rand_ack[%0d]: got %0b want %0b", i, wr_ack, exp_ack); end
      n_cmp++; if (rd_valid !== exp_valid) begin n_err++; $display("FAIL rand_valid[%0d]: got %0b want %0b", i, rd_valid, exp_valid); end
      n_cmp++; if (rd_data !== exp_data) begin n_err++; $display("FAIL rand_data[%0d]: got %0h want %0h", i, rd_data, exp_data); end
      n_cmp++; if (wr_full !== (q.size() == DEPTH) || rd_empty !== (q.size() == 0)) begin n_err++; $display("FAIL rand_flags[%0d]: got full=%0b empty=%0b occupancy %0d", i, wr_full, rd_empty, q.size()); end
      n_cmp++; if (int'(data_count) != exp_cnt()) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, data_count, exp_cnt()); end
    end
    while (q.size() > 0) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] aa;
    aa = {BW{8'hAA}};
    for (int i = 0; i < 10; i++) cyc(1'b1, rnd(), 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);
    cyc(1'b1, rnd(), 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (rd_empty !== 1'b1 || wr_full !== 1'b0) begin n_err++; $display("FAIL arst_flags: got empty=%0b full=%0b want 1/0", rd_empty, wr_full); end
    n_cmp++; if (wr_ack !== 1'b0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_pulses: got ack=%0b valid=%0b want 0/0", wr_ack, rd_valid); end
    n_cmp++; if (rd_data !== '0 || data_count !== '0) begin n_err++; $display("FAIL arst_data: got data=%0h count=%0d want 0/0", rd_data, data_count); end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = rnd();
    @(posedge clk); #1;
    n_cmp++; if (wr_ack !== 1'b0 || rd_empty !== 1'b1 || rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_held: got ack=%0b empty=%0b valid=%0b want 0/1/0", wr_ack, rd_empty, rd_valid); end
    #3 rst = 1'b0;
    cyc(1'b1, aa, 1'b0);
    cyc(1'b1, rnd(), 1'b1);
    n_cmp++; if (rd_valid !== 1'b1 || rd_data !== aa) begin n_err++; $display("FAIL arst_first_read: got valid=%0b data=%0h want 1/%0h", rd_valid, rd_data, aa); end
    n_cmp++; if (int'(data_count) != exp_cnt()) begin n_err++; $display("FAIL arst_count: got %0d want %0d", data_count, exp_cnt()); end
    while (q.size() > 0) cyc(1'b0, '0, 1'b1);
  endtask

  task automatic test_loopback();
    localparam int N = 700;
    logic [DW-1:0] src[N];
    logic [DW-1:0] sink[$];
    int s = 0;
    int cycles = 0;
    int stalls = 0;
    bit full_now, we;
    for (int i = 0; i < N; i++) src[i] = rnd();
    while (sink.size() < N && cycles < 8000) begin
      full_now = wr_full;
      we = s < N;
      if (we && full_now) stalls++;
      cyc(we, we ? src[s] : '0, $urandom_range(0, 1) == 1);
      if (we && !full_now) s++;
      if (rd_valid === 1'b1) sink.push_back(rd_data);
      cycles++;
    end
    n_cmp++; if (sink.size() != N) begin n_err++; $display("FAIL loop_length: got %0d want %0d", sink.size(), N); end
    for (int i = 0; i < N && i < sink.size(); i++) begin
      n_cmp++; if (sink[i] !== src[i]) begin n_err++; $display("FAIL loop_word[%0d]: got %0h want %0h", i, sink[i], src[i]); end
    end
    n_cmp++; if (stalls == 0) begin n_err++; $display("FAIL loop_throttle: got %0d stalls want >0", stalls); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_boundary();
    test_stream();
    test_random();
    test_async_reset();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
